// File: rtl/alu_mult_sequencer_if.sv
// Operand/result bundle between the execute stage and the multiply sequencer.
// Latency: none, wires only.
// Backpressure: the sequencer's stall output holds the issuing stage.
interface alu_mult_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             issue;
    logic [3:0]       ALU_Cnt;
    logic             flush;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             stall;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] product_lo;
    logic [WIDTH-1:0] product_hi;

    // Execute stage side: issues operations and observes stall/result.
    modport master (
        output issue, ALU_Cnt, flush, op_a, op_b,
        input  stall, busy, done, product_lo, product_hi
    );

    // Sequencer side.
    modport slave (
        input  issue, ALU_Cnt, flush, op_a, op_b,
        output stall, busy, done, product_lo, product_hi
    );
endinterface

// File: rtl/alu_mult_sequencer.sv
// Multi-cycle unsigned shift-add multiplier for ALU_Cnt 4'b0111.
// Latency: issue at cycle 0, WIDTH RUN cycles, one-cycle done at cycle WIDTH+1.
// Backpressure: stall is high from the issue cycle through the last RUN cycle.
module alu_mult_sequencer #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    alu_mult_sequencer_if.slave  bus
);
    localparam logic [3:0]       MULT_CODE = 4'b0111;
    localparam logic [CNT_W-1:0] CNT_INIT  = CNT_W'(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] counter;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] prod_hi;
    logic [WIDTH-1:0] prod_lo;
    logic [WIDTH:0]   sum;
    logic             is_mult;
    logic             load;
    logic             capture;
    logic             stall_c;
    logic             busy_c;
    logic             done_c;

    assign is_mult = bus.issue && (bus.ALU_Cnt == MULT_CODE);

    // Partial-product add keeps the carry so the top product bit is never lost.
    assign sum = mplier[0] ? ({1'b0, acc} + {1'b0, mcand}) : {1'b0, acc};

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode and handshake outputs; flush drops stall/done immediately.
    always_comb begin
        state_nxt = state;
        stall_c   = 1'b0;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        load      = 1'b0;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                stall_c = is_mult;
                if (is_mult && !bus.flush) begin
                    state_nxt = RUN;
                    load      = 1'b1;
                end
            end
            RUN: begin
                busy_c  = 1'b1;
                stall_c = !bus.flush;
                if (bus.flush) begin
                    state_nxt = IDLE;
                end else if (counter == CNT_LAST) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                // Unconditional return to IDLE so the committing instruction
                // cannot re-trigger itself.
                done_c    = !bus.flush;
                capture   = !bus.flush;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operand latch, shift-add iteration, and committed product hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            mcand   <= '0;
            mplier  <= '0;
            acc     <= '0;
            prod_hi <= '0;
            prod_lo <= '0;
        end else begin
            if (load) begin
                mcand   <= bus.op_a;
                mplier  <= bus.op_b;
                acc     <= '0;
                counter <= CNT_INIT;
            end else if (state == RUN && !bus.flush) begin
                acc     <= sum[WIDTH:1];
                mplier  <= {sum[0], mplier[WIDTH-1:1]};
                counter <= counter - CNT_LAST;
            end else if (bus.flush) begin
                counter <= '0;
            end
            if (capture) begin
                prod_hi <= acc;
                prod_lo <= mplier;
            end
        end
    end

    assign bus.stall      = stall_c;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;
    // The DONE cycle shows the fresh result; otherwise the last committed one.
    assign bus.product_hi = (state == DONE) ? acc    : prod_hi;
    assign bus.product_lo = (state == DONE) ? mplier : prod_lo;
endmodule

// File: tb/tb_alu_mult_sequencer.sv
// Directed bench for the multiply sequencer.
// Latency: checks issue-to-done timing and stall length.
// Backpressure: observes stall/busy under flush, reset and back-to-back issue.
module tb_alu_mult_sequencer;
    logic clk;
    logic reset;
    int   n_chk;
    int   n_pass;
    int   stall_seen;
    int   busy_seen;
    int   done_seen;

    alu_mult_sequencer_if #(.WIDTH(16)) bus ();

    alu_mult_sequencer #(.WIDTH(16), .CNT_W(5)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Issue one multiply and follow it to its done cycle (bounded).
    task automatic mult_op(input logic [15:0] a, input logic [15:0] b,
                           input bit hold_issue, input bit scramble,
                           input logic [31:0] exp, input string tag);
        int cyc;
        int stalls;
        @(posedge clk); #1;
        bus.issue   = 1'b1;
        bus.ALU_Cnt = 4'b0111;
        bus.op_a    = a;
        bus.op_b    = b;
        #1;
        check({tag, " cyc0 stall"}, 64'(bus.stall), 64'd1);
        check({tag, " cyc0 busy"}, 64'(bus.busy), 64'd0);
        stalls = 1;
        cyc    = 0;
        while (bus.done !== 1'b1 && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
            if (!hold_issue) bus.issue = 1'b0;
            if (scramble) begin
                bus.op_a = 16'($urandom);
                bus.op_b = 16'($urandom);
            end
            #1;
            if (bus.stall === 1'b1) stalls++;
        end
        check({tag, " done cycle"}, 64'(cyc), 64'd17);
        check({tag, " stall cycles"}, 64'(stalls), 64'd17);
        check({tag, " stall at done"}, 64'(bus.stall), 64'd0);
        check({tag, " product"}, 64'({bus.product_hi, bus.product_lo}), 64'(exp));
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        reset       = 1'b1;
        bus.issue   = 1'b0;
        bus.ALU_Cnt = 4'b0000;
        bus.flush   = 1'b0;
        bus.op_a    = '0;
        bus.op_b    = '0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("reset stall", 64'(bus.stall), 64'd0);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset done", 64'(bus.done), 64'd0);
        check("reset product", 64'({bus.product_hi, bus.product_lo}), 64'd0);

        mult_op(16'd3, 16'd5, 1'b0, 1'b0, 32'h0000_000F, "basic");
        @(posedge clk); #2;
        check("basic done pulse width", 64'(bus.done), 64'd0);
        check("basic product hold", 64'({bus.product_hi, bus.product_lo}), 64'h0000_000F);

        mult_op(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE_0001, "max");

        // Non-multiply codes must never stall.
        stall_seen = 0;
        busy_seen  = 0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            bus.issue   = 1'b1;
            bus.ALU_Cnt = (i < 3) ? 4'b0100 : 4'b1100;
            bus.op_a    = 16'd9;
            bus.op_b    = 16'd9;
            #1;
            if (bus.stall === 1'b1) stall_seen++;
            if (bus.busy === 1'b1) busy_seen++;
        end
        bus.issue = 1'b0;
        check("nonmult stall cycles", 64'(stall_seen), 64'd0);
        check("nonmult busy cycles", 64'(busy_seen), 64'd0);
        check("nonmult product", 64'({bus.product_hi, bus.product_lo}), 64'hFFFE_0001);

        // Flush at RUN cycle 8.
        @(posedge clk); #1;
        bus.issue   = 1'b1;
        bus.ALU_Cnt = 4'b0111;
        bus.op_a    = 16'h1234;
        bus.op_b    = 16'h0010;
        for (int i = 1; i < 8; i++) begin
            @(posedge clk); #1;
            bus.issue = 1'b0;
        end
        @(posedge clk); #1;
        bus.flush = 1'b1;
        #1;
        check("flush cycle busy", 64'(bus.busy), 64'd1);
        check("flush cycle stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #1;
        bus.flush = 1'b0;
        #1;
        check("after flush busy", 64'(bus.busy), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #2;
            if (bus.done === 1'b1) done_seen++;
        end
        check("flush no done", 64'(done_seen), 64'd0);
        check("flush product kept", 64'({bus.product_hi, bus.product_lo}), 64'hFFFE_0001);

        // Operands change every RUN cycle; result must use the latched pair.
        mult_op(16'h1234, 16'h0056, 1'b0, 1'b1, 32'h0006_1D78, "latched");

        // Reset in the middle of RUN.
        @(posedge clk); #1;
        bus.issue   = 1'b1;
        bus.ALU_Cnt = 4'b0111;
        bus.op_a    = 16'd3;
        bus.op_b    = 16'd5;
        repeat (5) begin
            @(posedge clk); #1;
            bus.issue = 1'b0;
        end
        #1;
        check("pre-reset busy", 64'(bus.busy), 64'd1);
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("midrun reset stall", 64'(bus.stall), 64'd0);
        check("midrun reset busy", 64'(bus.busy), 64'd0);
        check("midrun reset done", 64'(bus.done), 64'd0);
        check("midrun reset product", 64'({bus.product_hi, bus.product_lo}), 64'd0);

        // Back-to-back with issue held through DONE: no re-trigger from DONE.
        mult_op(16'd7, 16'd9, 1'b1, 1'b0, 32'h0000_003F, "b2b first");
        mult_op(16'd0, 16'hFFFF, 1'b1, 1'b0, 32'h0000_0000, "b2b second");
        @(posedge clk); #1;
        bus.issue = 1'b0;
        #1;
        check("b2b idle stall", 64'(bus.stall), 64'd0);
        @(posedge clk); #2;
        check("b2b idle busy", 64'(bus.busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/alu_mult_sequencer.md
Name: alu_mult_sequencer

Overview:
- Multi-cycle shift-add sequencer for the ALU multiply operation (ALU_Cnt = 4'b0111).
- Sits beside the ALU and the ALU control decoder. When a multiply is issued, it latches the operands, stalls the PC/register-file write for WIDTH+1 cycles, runs WIDTH shift-add iterations, then presents a 2*WIDTH-bit product for exactly one commit cycle.
- All other ALU_Cnt codes pass with zero stall.

Parameters:
- WIDTH, 16, operand width in bits; product is 2*WIDTH bits.
- CNT_W, 5, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- issue  input  1  current instruction is valid in the execute stage.
- ALU_Cnt  input  4  ALU control code from the ALU control decoder.
- flush  input  1  abort any in-flight multiply, synchronous.
- op_a  input  WIDTH  multiplicand, from register file read port 1.
- op_b  input  WIDTH  multiplier, from register file read port 2.
- stall  output  1  hold PC and suppress register write-back.
- busy  output  1  sequencer is in RUN.
- done  output  1  one-cycle pulse; product valid and committable.
- product_lo  output  WIDTH  low half of the product.
- product_hi  output  WIDTH  high half of the product.

Behaviour:
- Reset values: state=IDLE, counter=0, product_hi/product_lo=0, busy=0, done=0, stall=0.
- Decode: is_mult = issue && (ALU_Cnt == 4'b0111). Codes 0000/0001/0010/0011/0100/0110/1100 never stall.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - stall = is_mult (combinational, same cycle as issue).
  - On an edge with is_mult=1 and flush=0: load mcand<=op_a, mplier<=op_b, acc<=0, counter<=WIDTH, go to RUN.
- RUN:
  - stall=1, busy=1.
  - Each edge: if mplier[0]=1, {carry, acc_upper} = acc_upper + mcand (WIDTH+1-bit add).
  - Then {carry, acc_upper, mplier} shifts right by 1; counter decrements.
  - When counter reaches 1 on that edge, go to DONE. RUN therefore lasts exactly WIDTH cycles.
- DONE:
  - stall=0, done=1, product_hi=acc_upper, product_lo=mplier-reg.
  - Next edge always returns to IDLE, regardless of issue. This prevents re-triggering on the instruction being committed.
- Product registers hold their last value in IDLE until the next accepted multiply.
- Latency: issue seen at cycle 0; RUN occupies cycles 1..WIDTH; done at cycle WIDTH+1.
  - stall is high for cycles 0..WIDTH (WIDTH+1 cycles) and low at cycle WIDTH+1.
- Arithmetic: unsigned only. The full 2*WIDTH product is exact with no overflow; the carry bit is never lost.
- Operand changes on op_a/op_b after cycle 0 are ignored, because operands are latched.
- flush:
  - In RUN or DONE: next edge goes to IDLE, counter=0, no done pulse; product registers keep their previous value. stall drops combinationally in the flush cycle.
  - In IDLE: blocks acceptance.
- reset mid-operation: overrides flush and issue; returns all state to reset values on that edge.
- Operand corner cases: op_a=0 or op_b=0 gives product 0 and still takes the full latency (no early-out).

Test Plan:
- Reset: assert reset for 2 cycles mid-RUN -> next cycle state IDLE, stall=0, busy=0, done=0, product=0.
- Basic multiply (WIDTH=16): op_a=3, op_b=5, ALU_Cnt=0111 -> stall high for 17 cycles, done at cycle 17, product_hi=0x0000, product_lo=0x000F.
- Maximum operands: op_a=0xFFFF, op_b=0xFFFF -> product_hi=0xFFFE, product_lo=0x0001; carry propagation is checked.
- Non-multiply codes: ALU_Cnt=0100 and then 1100 with issue=1 -> stall=0, busy=0 every cycle, product unchanged.
- Flush and operand stability: flush at RUN cycle 8 -> IDLE next edge, no done, product keeps its prior value. In a separate run, change op_a/op_b during RUN -> result reflects the latched operands.
- Back-to-back multiplies: 7*9 then 0*0xFFFF with issue held through DONE -> the DONE cycle does not retrigger; second accept occurs in the following IDLE cycle, and the second product is 0 after a full 17 cycles.
